// File: rtl/jump_issue_ctrl_pkg.sv
// rtl/jump_issue_ctrl_pkg.sv - shared types and constants for the jump issue controller
package jump_issue_ctrl_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DISPATCH = 3'd1,
        ST_WAIT     = 3'd2,
        ST_RESOLVE  = 3'd3,
        ST_WB       = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        JTYPE_BRANCH = 2'd0,
        JTYPE_JAL    = 2'd1,
        JTYPE_JALR   = 2'd2
    } jtype_t;

    // The reserved encoding folds into BRANCH so downstream logic only sees three kinds.
    function automatic jtype_t decode_type(input logic [1:0] raw);
        case (raw)
            2'd1:    return JTYPE_JAL;
            2'd2:    return JTYPE_JALR;
            default: return JTYPE_BRANCH;
        endcase
    endfunction

    function automatic logic is_link_type(input jtype_t t);
        return (t == JTYPE_JAL) || (t == JTYPE_JALR);
    endfunction

endpackage

// File: rtl/jump_watchdog.sv
// rtl/jump_watchdog.sv - WAIT-state cycle counter that flags a missing FU finish
module jump_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && !expire) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/jump_issue_ctrl.sv
// rtl/jump_issue_ctrl.sv - issue-side controller for the jump/branch functional unit
module jump_issue_ctrl
    import jump_issue_ctrl_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [1:0]      issue_type,
    input  logic [2:0]      issue_cmp,
    input  logic [4:0]      issue_rd,
    input  logic [XLEN-1:0] issue_rs1,
    input  logic [XLEN-1:0] issue_rs2,
    input  logic [XLEN-1:0] issue_imm,
    input  logic [XLEN-1:0] issue_pc,
    output logic            fu_en,
    output logic            fu_jalr,
    output logic [2:0]      fu_cmp,
    output logic [XLEN-1:0] fu_rs1,
    output logic [XLEN-1:0] fu_rs2,
    output logic [XLEN-1:0] fu_imm,
    output logic [XLEN-1:0] fu_pc,
    input  logic            fu_finish,
    input  logic [XLEN-1:0] fu_pc_jump,
    input  logic [XLEN-1:0] fu_pc_wb,
    input  logic            fu_cmp_res,
    output logic            redirect_vld,
    output logic [XLEN-1:0] redirect_pc,
    output logic            exc_misalign,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            err_timeout,
    output logic            busy
);

    state_t          state_q, state_d;
    jtype_t          type_q;
    logic [2:0]      cmp_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rs1_q, rs2_q, imm_q, pc_q;
    logic [XLEN-1:0] pc_jump_q, pc_wb_q;
    logic            cmp_res_q;

    logic            accept;
    logic            link;
    logic            taken;
    logic            misalign;
    logic [XLEN-1:0] target;
    logic            wd_clear, wd_count, wd_expire;

    jump_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wd_clear),
        .count_en (wd_count),
        .expire   (wd_expire)
    );

    assign accept = issue_valid && (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_q    <= JTYPE_BRANCH;
            cmp_q     <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            pc_jump_q <= '0;
            pc_wb_q   <= '0;
            cmp_res_q <= 1'b0;
        end else begin
            if (accept) begin
                type_q <= decode_type(issue_type);
                cmp_q  <= issue_cmp;
                rd_q   <= issue_rd;
                rs1_q  <= issue_rs1;
                rs2_q  <= issue_rs2;
                imm_q  <= issue_imm;
                pc_q   <= issue_pc;
            end
            if ((state_q == ST_WAIT) && fu_finish) begin
                pc_jump_q <= fu_pc_jump;
                pc_wb_q   <= fu_pc_wb;
                cmp_res_q <= fu_cmp_res;
            end
        end
    end

    // JALR clears bit 0 of its target; any remaining low bit set on a taken jump is a fault.
    always_comb begin
        target = pc_jump_q;
        if (type_q == JTYPE_JALR) begin
            target[0] = 1'b0;
        end
    end

    assign link     = is_link_type(type_q);
    assign taken    = link || cmp_res_q;
    assign misalign = taken && (target[1:0] != 2'b00);

    assign fu_jalr = (type_q == JTYPE_JALR);
    assign fu_cmp  = cmp_q;
    assign fu_rs1  = rs1_q;
    assign fu_rs2  = rs2_q;
    assign fu_imm  = imm_q;
    assign fu_pc   = pc_q;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        issue_ready  = 1'b0;
        fu_en        = 1'b0;
        redirect_vld = 1'b0;
        redirect_pc  = '0;
        exc_misalign = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        err_timeout  = 1'b0;
        wd_clear     = 1'b0;
        wd_count     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) begin
                    state_d = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                fu_en    = 1'b1;
                wd_clear = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (fu_finish) begin
                    state_d = ST_RESOLVE;
                end else if (wd_expire) begin
                    err_timeout = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wd_count = 1'b1;
                end
            end
            ST_RESOLVE: begin
                if (taken && !misalign) begin
                    redirect_vld = 1'b1;
                    redirect_pc  = target;
                end
                exc_misalign = misalign;
                if (link && (rd_q != 5'd0) && !misalign) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                wb_valid = 1'b1;
                wb_rd    = rd_q;
                wb_data  = pc_wb_q;
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_jump_issue_ctrl.sv
// tb/tb_jump_issue_ctrl.sv - randomized self-checking bench for jump_issue_ctrl
module tb_jump_issue_ctrl;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 15;

    logic            clk;
    logic            rst_n;
    logic            issue_valid;
    logic            issue_ready;
    logic [1:0]      issue_type;
    logic [2:0]      issue_cmp;
    logic [4:0]      issue_rd;
    logic [XLEN-1:0] issue_rs1, issue_rs2, issue_imm, issue_pc;
    logic            fu_en, fu_jalr;
    logic [2:0]      fu_cmp;
    logic [XLEN-1:0] fu_rs1, fu_rs2, fu_imm, fu_pc;
    logic            fu_finish;
    logic [XLEN-1:0] fu_pc_jump, fu_pc_wb;
    logic            fu_cmp_res;
    logic            redirect_vld;
    logic [XLEN-1:0] redirect_pc;
    logic            exc_misalign;
    logic            wb_valid, wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            err_timeout, busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    jump_issue_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_type   (issue_type),
        .issue_cmp    (issue_cmp),
        .issue_rd     (issue_rd),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_imm    (issue_imm),
        .issue_pc     (issue_pc),
        .fu_en        (fu_en),
        .fu_jalr      (fu_jalr),
        .fu_cmp       (fu_cmp),
        .fu_rs1       (fu_rs1),
        .fu_rs2       (fu_rs2),
        .fu_imm       (fu_imm),
        .fu_pc        (fu_pc),
        .fu_finish    (fu_finish),
        .fu_pc_jump   (fu_pc_jump),
        .fu_pc_wb     (fu_pc_wb),
        .fu_cmp_res   (fu_cmp_res),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .exc_misalign (exc_misalign),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .err_timeout  (err_timeout),
        .busy         (busy)
    );

    typedef struct packed {
        logic        ready;
        logic        busy;
        logic        fu_en;
        logic        fu_jalr;
        logic        rvld;
        logic        exc;
        logic        wbv;
        logic        tmo;
        logic        chk_fu;
        logic [2:0]  cmp;
        logic [4:0]  wbrd;
        logic [31:0] rpc;
        logic [31:0] wbd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    int          checks = 0;
    int          failures = 0;
    int          n_redirect = 0, n_exc = 0, n_wb = 0, n_tmo = 0;
    logic [31:0] last_rpc = '0, last_wbd = '0;
    logic [4:0]  last_wbrd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            chk("issue_ready",  32'(issue_ready),  32'(ce.ready));
            chk("busy",         32'(busy),         32'(ce.busy));
            chk("fu_en",        32'(fu_en),        32'(ce.fu_en));
            chk("redirect_vld", 32'(redirect_vld), 32'(ce.rvld));
            chk("redirect_pc",  redirect_pc,       ce.rpc);
            chk("exc_misalign", 32'(exc_misalign), 32'(ce.exc));
            chk("wb_valid",     32'(wb_valid),     32'(ce.wbv));
            chk("wb_rd",        32'(wb_rd),        32'(ce.wbrd));
            chk("wb_data",      wb_data,           ce.wbd);
            chk("err_timeout",  32'(err_timeout),  32'(ce.tmo));
            if (ce.chk_fu) begin
                chk("fu_jalr", 32'(fu_jalr), 32'(ce.fu_jalr));
                chk("fu_cmp",  32'(fu_cmp),  32'(ce.cmp));
                chk("fu_rs1",  fu_rs1,       ce.rs1);
                chk("fu_rs2",  fu_rs2,       ce.rs2);
                chk("fu_imm",  fu_imm,       ce.imm);
                chk("fu_pc",   fu_pc,        ce.pc);
            end
        end
        if (redirect_vld) begin
            n_redirect++;
            last_rpc = redirect_pc;
        end
        if (exc_misalign) n_exc++;
        if (err_timeout) n_tmo++;
        if (wb_valid && wb_ready) begin
            n_wb++;
            last_wbd  = wb_data;
            last_wbrd = wb_rd;
        end
    end

    function automatic exp_t idle_vec();
        exp_t e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    function automatic exp_t rst_vec();
        exp_t e = '0;
        e.ready  = 1'b1;
        e.chk_fu = 1'b1;
        return e;
    endfunction

    // Reference branch comparator standing in for the FU.
    function automatic logic br_cmp(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic noise();
        fu_finish   = 1'($urandom);
        fu_pc_jump  = $urandom;
        fu_pc_wb    = $urandom;
        fu_cmp_res  = 1'($urandom);
        wb_ready    = 1'($urandom);
        issue_valid = 1'($urandom);
        issue_type  = 2'($urandom);
        issue_cmp   = 3'($urandom);
        issue_rd    = 5'($urandom);
        issue_rs1   = $urandom;
        issue_rs2   = $urandom;
        issue_imm   = $urandom;
        issue_pc    = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            noise();
            issue_valid = 1'b0;
            rst_n = 1'b1;
            exp_q.push_back(idle_vec());
        end
    endtask

    // One jump as a timeline of expected per-cycle outputs. d: FU finish on the d-th
    // WAIT cycle (0 = never); s: wb_ready low cycles; ab: reset on that WAIT cycle (-1 = none).
    task automatic run_jump(input logic [1:0] t, input logic [2:0] c, input logic [4:0] rd,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] imm, input logic [31:0] pc,
                            input int d, input int s, input int ab);
        logic        is_jalr, is_link, cres, taken, mis, resolves;
        logic [31:0] pjump, pwb, tgt;
        int          nwait;
        exp_t        b, e;
        is_jalr  = (t == 2'd2);
        is_link  = (t == 2'd1) || (t == 2'd2);
        pjump    = is_jalr ? rs1 + imm : pc + imm;
        pwb      = pc + 32'd4;
        cres     = br_cmp(c, rs1, rs2);
        taken    = is_link || cres;
        tgt      = is_jalr ? (pjump & 32'hFFFF_FFFE) : pjump;
        mis      = taken && (tgt[1:0] != 2'b00);
        resolves = (d >= 1) && (d <= TIMEOUT);
        nwait    = resolves ? d : TIMEOUT;

        b = '0;
        b.busy = 1'b1; b.chk_fu = 1'b1; b.fu_jalr = is_jalr; b.cmp = c;
        b.rs1 = rs1; b.rs2 = rs2; b.imm = imm; b.pc = pc;

        @(posedge clk); #1;
        noise();
        issue_valid = 1'b1; issue_type = t; issue_cmp = c; issue_rd = rd;
        issue_rs1 = rs1; issue_rs2 = rs2; issue_imm = imm; issue_pc = pc;
        exp_q.push_back(idle_vec());

        @(posedge clk); #1;
        noise();
        e = b; e.fu_en = 1'b1;
        exp_q.push_back(e);

        for (int w = 0; w < nwait; w++) begin
            @(posedge clk); #1;
            noise();
            fu_finish = resolves && (w == d - 1);
            if (fu_finish) begin
                fu_pc_jump = pjump;
                fu_pc_wb   = pwb;
                fu_cmp_res = cres;
            end
            if (w == ab) begin
                rst_n = 1'b0;
                exp_q.push_back(rst_vec());
                @(posedge clk); #1;
                noise();
                issue_valid = 1'b0;
                rst_n = 1'b1;
                exp_q.push_back(idle_vec());
                return;
            end
            e = b; e.tmo = !resolves && (w == TIMEOUT - 1);
            exp_q.push_back(e);
        end
        if (!resolves) return;

        @(posedge clk); #1;
        noise();
        e = b; e.rvld = taken && !mis; e.rpc = (taken && !mis) ? tgt : 32'd0; e.exc = mis;
        exp_q.push_back(e);

        if (is_link && (rd != 5'd0) && !mis) begin
            for (int k = 0; k <= s; k++) begin
                @(posedge clk); #1;
                noise();
                wb_ready = (k == s);
                e = b; e.wbv = 1'b1; e.wbrd = rd; e.wbd = pwb;
                exp_q.push_back(e);
            end
        end
    endtask

    int r0, x0, w0, t0;

    initial begin
        rst_n = 1'b0;
        noise();
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            noise();
            issue_valid = 1'b0;
            exp_q.push_back(rst_vec());
        end
        idle_cycles(2);

        // JAL with link writeback, FU finishing right after EN
        r0 = n_redirect; w0 = n_wb;
        run_jump(2'd1, 3'd0, 5'd1, 32'h0, 32'h0, 32'h20, 32'h100, 1, 0, -1);
        idle_cycles(1);
        chk("t1_redirects", n_redirect - r0, 1);
        chk("t1_redirect_pc", last_rpc, 32'h120);
        chk("t1_wbs", n_wb - w0, 1);
        chk("t1_wb_data", last_wbd, 32'h104);
        chk("t1_wb_rd", 32'(last_wbrd), 1);

        // BEQ taken, then not taken
        r0 = n_redirect; w0 = n_wb;
        run_jump(2'd0, 3'd0, 5'd3, 32'd5, 32'd5, 32'hFFFF_FFF8, 32'h200, 1, 0, -1);
        idle_cycles(1);
        chk("t2a_redirects", n_redirect - r0, 1);
        chk("t2a_redirect_pc", last_rpc, 32'h1F8);
        chk("t2a_wbs", n_wb - w0, 0);
        r0 = n_redirect;
        run_jump(2'd0, 3'd0, 5'd3, 32'd5, 32'd6, 32'hFFFF_FFF8, 32'h200, 1, 0, -1);
        idle_cycles(1);
        chk("t2b_redirects", n_redirect - r0, 0);
        chk("t2b_wbs", n_wb - w0, 0);

        // JALR bit0 clear, then misaligned target
        r0 = n_redirect; x0 = n_exc;
        run_jump(2'd2, 3'd0, 5'd0, 32'h301, 32'h0, 32'h0, 32'h400, 1, 0, -1);
        idle_cycles(1);
        chk("t3a_redirect_pc", last_rpc, 32'h300);
        chk("t3a_redirects", n_redirect - r0, 1);
        r0 = n_redirect;
        run_jump(2'd2, 3'd0, 5'd5, 32'h302, 32'h0, 32'h0, 32'h400, 1, 0, -1);
        idle_cycles(1);
        chk("t3b_exc", n_exc - x0, 1);
        chk("t3b_redirects", n_redirect - r0, 0);

        // FU never finishes, then finish on the very last WAIT cycle
        t0 = n_tmo;
        run_jump(2'd1, 3'd0, 5'd2, 32'h0, 32'h0, 32'h8, 32'h500, 0, 0, -1);
        run_jump(2'd1, 3'd0, 5'd2, 32'h0, 32'h0, 32'h8, 32'h500, TIMEOUT, 0, -1);
        idle_cycles(1);
        chk("t4_timeouts", n_tmo - t0, 1);
        chk("t4_last_redirect", last_rpc, 32'h508);

        // writeback stalled four cycles
        run_jump(2'd1, 3'd0, 5'd9, 32'h0, 32'h0, 32'h40, 32'h600, 2, 4, -1);
        idle_cycles(1);
        chk("t5_wb_data", last_wbd, 32'h604);

        // reset during WAIT, then a normal JAL
        w0 = n_wb;
        run_jump(2'd1, 3'd0, 5'd4, 32'h0, 32'h0, 32'h10, 32'h700, 0, 0, 2);
        run_jump(2'd1, 3'd0, 5'd4, 32'h0, 32'h0, 32'h10, 32'h700, 1, 0, -1);
        idle_cycles(1);
        chk("t6_redirect_pc", last_rpc, 32'h710);
        chk("t6_wbs", n_wb - w0, 1);

        for (int n = 0; n < 250; n++) begin
            logic [1:0]  t;
            logic [2:0]  c;
            logic [4:0]  rd;
            logic [31:0] a, bb, im, p;
            int          d, sel;
            t   = 2'($urandom);
            c   = 3'($urandom);
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            a   = $urandom;
            bb  = ($urandom_range(0, 2) == 0) ? a : $urandom;
            p   = $urandom & 32'hFFFF_FFFC;
            im  = (t == 2'd2) ? $urandom : ($urandom & 32'hFFFF_FFFE);
            sel = $urandom_range(0, 9);
            if (sel < 6)       d = 1;
            else if (sel == 6) d = $urandom_range(2, 4);
            else if (sel == 7) d = TIMEOUT;
            else if (sel == 8) d = TIMEOUT + 1;
            else               d = 0;
            run_jump(t, c, rd, a, bb, im, p, d, $urandom_range(0, 3), -1);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end

        idle_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
